// File: rtl/extram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : extram_arbiter
// Description : Round-robin arbiter for two CPUs sharing one asynchronous SRAM.
//               Registered strobes; SETUP / ACCESS(WAIT_CYCLES) / DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module extram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int BANKED      = 1
) (
    input  logic        clk40_i,
    input  logic        reset_n_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [15:0] addr0_i,
    input  logic [15:0] addr1_i,
    input  logic [7:0]  wdata0_i,
    input  logic [7:0]  wdata1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [7:0]  rdata_o,
    output logic [18:0] addr_o,
    output logic [7:0]  data_o,
    output logic        data_oe_o,
    input  logic [7:0]  data_i,
    output logic        cen_n_o,
    output logic        oen_n_o,
    output logic        wen_n_o,
    output logic        grant_o,
    output logic        busy_o
);

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_last_grant;
    logic        r_we;

    logic        w_winner;
    logic        w_win_we;
    logic [15:0] w_win_addr;
    logic [7:0]  w_win_wdata;
    logic        w_bank;
    logic        w_latch;
    logic        w_capture;
    logic        w_cen_nxt;
    logic        w_oen_nxt;
    logic        w_wen_nxt;
    logic        w_oe_nxt;
    logic        w_ack0_nxt;
    logic        w_ack1_nxt;

    // On a tie the requester that was not served last time wins.
    assign w_winner    = (req0_i && req1_i) ? ~r_last_grant : req1_i;
    assign w_win_we    = w_winner ? we1_i    : we0_i;
    assign w_win_addr  = w_winner ? addr1_i  : addr0_i;
    assign w_win_wdata = w_winner ? wdata1_i : wdata0_i;

    generate
        if (BANKED != 0) begin : g_banked
            assign w_bank = w_winner;
        end else begin : g_flat
            assign w_bank = 1'b0;
        end
    endgenerate

    // Strobe values are computed for the state being entered and registered,
    // so every SRAM control pin comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_cen_nxt   = 1'b1;
        w_oen_nxt   = 1'b1;
        w_wen_nxt   = 1'b1;
        w_oe_nxt    = 1'b0;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    w_state_nxt = S_SETUP;
                    w_latch     = 1'b1;
                    w_cen_nxt   = 1'b0;
                    w_oe_nxt    = w_win_we;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
                w_cnt_nxt   = c_WAIT_LOAD;
                w_cen_nxt   = 1'b0;
                w_oen_nxt   = r_we;
                w_wen_nxt   = ~r_we;
                w_oe_nxt    = r_we;
            end
            S_ACCESS: begin
                w_cen_nxt = 1'b0;
                w_oe_nxt  = r_we;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                    w_capture   = ~r_we;
                    w_ack0_nxt  = ~grant_o;
                    w_ack1_nxt  = grant_o;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    w_oen_nxt = r_we;
                    w_wen_nxt = ~r_we;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk40_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk40_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cen_n_o      <= 1'b1;
            oen_n_o      <= 1'b1;
            wen_n_o      <= 1'b1;
            data_oe_o    <= 1'b0;
            ack0_o       <= 1'b0;
            ack1_o       <= 1'b0;
            addr_o       <= 19'd0;
            data_o       <= 8'd0;
            rdata_o      <= 8'd0;
            grant_o      <= 1'b0;
            busy_o       <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
        end else begin
            cen_n_o   <= w_cen_nxt;
            oen_n_o   <= w_oen_nxt;
            wen_n_o   <= w_wen_nxt;
            data_oe_o <= w_oe_nxt;
            ack0_o    <= w_ack0_nxt;
            ack1_o    <= w_ack1_nxt;
            busy_o    <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_we         <= w_win_we;
                r_last_grant <= w_winner;
                grant_o      <= w_winner;
                addr_o       <= {2'b00, w_bank, w_win_addr};
                if (w_win_we) begin
                    data_o <= w_win_wdata;
                end
            end
            if (w_capture) begin
                rdata_o <= data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_extram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_extram_arbiter
// Description : Self-checking bench for extram_arbiter (vectors + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extram_arbiter;

    localparam int W = 2;

    typedef struct packed {
        logic        g;
        logic [18:0] addr;
        logic        we;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [15:0] a0, a1;
        logic [7:0]  d0, d1, di;
        exp_t        e;
    } vec_t;

    logic        clk40_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        req0_i = 1'b0, req1_i = 1'b0, we0_i = 1'b0, we1_i = 1'b0;
    logic [15:0] addr0_i = '0, addr1_i = '0;
    logic [7:0]  wdata0_i = '0, wdata1_i = '0, data_i = '0;

    logic        ack0_o, ack1_o, data_oe_o, cen_n_o, oen_n_o, wen_n_o, grant_o, busy_o;
    logic [7:0]  rdata_o, data_o;
    logic [18:0] addr_o;

    logic        ack0_w1, ack1_w1, oe_w1, cen_w1, oen_w1, wen_w1, grant_w1, busy_w1;
    logic [7:0]  rdata_w1, data_w1;
    logic [18:0] addr_w1;
    logic        ack0_w15, ack1_w15, oe_w15, cen_w15, oen_w15, wen_w15, grant_w15, busy_w15;
    logic [7:0]  rdata_w15, data_w15;
    logic [18:0] addr_w15;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic sb_en = 1'b1;
    exp_t sb[$];
    int   ack_cycles[$];
    vec_t vecs[8];

    always #12 clk40_i = ~clk40_i;
    always @(posedge clk40_i) cyc <= cyc + 1;

    extram_arbiter #(.WAIT_CYCLES(W), .BANKED(1)) u_dut (
        .clk40_i(clk40_i), .reset_n_i(reset_n_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .rdata_o(rdata_o), .addr_o(addr_o),
        .data_o(data_o), .data_oe_o(data_oe_o), .data_i(data_i),
        .cen_n_o(cen_n_o), .oen_n_o(oen_n_o), .wen_n_o(wen_n_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    extram_arbiter #(.WAIT_CYCLES(1), .BANKED(1)) u_w1 (
        .clk40_i(clk40_i), .reset_n_i(reset_n_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_w1), .ack1_o(ack1_w1), .rdata_o(rdata_w1), .addr_o(addr_w1),
        .data_o(data_w1), .data_oe_o(oe_w1), .data_i(data_i),
        .cen_n_o(cen_w1), .oen_n_o(oen_w1), .wen_n_o(wen_w1),
        .grant_o(grant_w1), .busy_o(busy_w1)
    );

    extram_arbiter #(.WAIT_CYCLES(15), .BANKED(0)) u_w15 (
        .clk40_i(clk40_i), .reset_n_i(reset_n_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_w15), .ack1_o(ack1_w15), .rdata_o(rdata_w15), .addr_o(addr_w15),
        .data_o(data_w15), .data_oe_o(oe_w15), .data_i(data_i),
        .cen_n_o(cen_w15), .oen_n_o(oen_w15), .wen_n_o(wen_w15),
        .grant_o(grant_w15), .busy_o(busy_w15)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r0, r1, we0, we1, input logic [15:0] a0, a1,
                                input logic [7:0] d0, d1, di, input exp_t e);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.di = di; v.e = e;
        return v;
    endfunction

    // Scoreboard and protocol monitor on the WAIT_CYCLES=2 instance.
    int c_oen = 0, c_wen = 0, c_oe = 0, c_busy = 0;
    always @(negedge clk40_i) begin
        exp_t e;
        check("strobe_overlap", {31'd0, !oen_n_o && !wen_n_o}, 32'd0);
        check("oe_during_read", {31'd0, data_oe_o && !oen_n_o}, 32'd0);
        if (ack0_o || ack1_o)
            check("ack_strobes", {ack0_o & ack1_o, cen_n_o, oen_n_o, wen_n_o, busy_o}, 5'b00111);
        if (!reset_n_i || !sb_en) begin
            c_oen = 0; c_wen = 0; c_oe = 0; c_busy = 0;
        end else begin
            if (!oen_n_o) c_oen++;
            if (!wen_n_o) c_wen++;
            if (data_oe_o) c_oe++;
            if (busy_o) c_busy++;
            if (ack0_o || ack1_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {ack0_o, ack1_o}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("ack_index", {ack0_o, ack1_o}, e.g ? 2'b01 : 2'b10);
                    check("grant", grant_o, e.g);
                    check("addr", addr_o, e.addr);
                    check("busy_cycles", c_busy, W + 2);
                    if (e.we) begin
                        check("wdata", data_o, e.data);
                        check("wen_cycles", c_wen, W);
                        check("oe_cycles", {c_oe, c_oen}, {32'(W + 2), 32'd0});
                    end else begin
                        check("rdata", rdata_o, e.data);
                        check("oen_cycles", c_oen, W);
                        check("read_no_we_oe", c_wen + c_oe, 0);
                    end
                end
                c_oen = 0; c_wen = 0; c_oe = 0; c_busy = 0;
            end
        end
    end

    task automatic wait_acks(input int n, input int budget);
        int seen = 0;
        ack_cycles.delete();
        for (int k = 0; k < budget && seen < n; k++) begin
            @(negedge clk40_i);
            if (ack0_o || ack1_o) begin
                seen++;
                ack_cycles.push_back(cyc);
            end
        end
        if (seen < n) check("ack_timeout", seen, n);
    endtask

    task automatic drop_reqs();
        @(posedge clk40_i); #1;
        req0_i = 1'b0;
        req1_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk40_i);
        reset_n_i = 1'b0;
        req0_i = 1'b0;
        req1_i = 1'b0;
        repeat (2) @(negedge clk40_i);
        reset_n_i = 1'b1;
    endtask

    task automatic check_idle(input logic [18:0] a);
        @(negedge clk40_i);
        check("idle_strobes", {cen_n_o, oen_n_o, wen_n_o, data_oe_o, busy_o, ack0_o, ack1_o}, 7'b1110000);
        check("idle_addr_hold", addr_o, a);
    endtask

    initial begin
        int   n0, c1, c15, lo1, lo15;
        logic got1, got15;

        vecs[0] = mk(1, 0, 0, 0, 16'h1234, 16'h0000, 8'h00, 8'h00, 8'hA5, '{1'b0, 19'h01234, 1'b0, 8'hA5});
        vecs[1] = mk(0, 1, 0, 1, 16'h0000, 16'h00FF, 8'h00, 8'h3C, 8'h00, '{1'b1, 19'h100FF, 1'b1, 8'h3C});
        vecs[2] = mk(1, 1, 0, 1, 16'hBEEF, 16'h0001, 8'h00, 8'h77, 8'h5A, '{1'b0, 19'h0BEEF, 1'b0, 8'h5A});
        vecs[3] = mk(1, 1, 1, 0, 16'h4321, 16'hFFFF, 8'h99, 8'h00, 8'hC3, '{1'b1, 19'h1FFFF, 1'b0, 8'hC3});
        vecs[4] = mk(0, 1, 0, 0, 16'h0000, 16'h8000, 8'h00, 8'h00, 8'h0F, '{1'b1, 19'h18000, 1'b0, 8'h0F});
        vecs[5] = mk(1, 1, 1, 1, 16'h0000, 16'h1111, 8'hFF, 8'h00, 8'h00, '{1'b0, 19'h00000, 1'b1, 8'hFF});
        vecs[6] = mk(1, 0, 1, 0, 16'hFFFF, 16'h0000, 8'h01, 8'h00, 8'h00, '{1'b0, 19'h0FFFF, 1'b1, 8'h01});
        vecs[7] = mk(1, 1, 0, 0, 16'h0F0F, 16'h2468, 8'h00, 8'h00, 8'h3C, '{1'b1, 19'h12468, 1'b0, 8'h3C});

        // Reset values
        repeat (3) @(negedge clk40_i);
        check("rst_strobes", {cen_n_o, oen_n_o, wen_n_o, data_oe_o}, 4'b1110);
        check("rst_acks_grant_busy", {ack0_o, ack1_o, grant_o, busy_o}, 4'b0000);
        check("rst_addr", addr_o, 19'd0);
        check("rst_data", {data_o, rdata_o}, 16'd0);
        reset_n_i = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk40_i); #1;
            req0_i = vecs[i].r0;  req1_i = vecs[i].r1;
            we0_i = vecs[i].we0;  we1_i = vecs[i].we1;
            addr0_i = vecs[i].a0; addr1_i = vecs[i].a1;
            wdata0_i = vecs[i].d0; wdata1_i = vecs[i].d1;
            data_i = vecs[i].di;
            sb.push_back(vecs[i].e);
            wait_acks(1, 20);
            drop_reqs();
            check_idle(vecs[i].e.addr);
        end

        // Inputs altered mid-access must not reach the SRAM pins
        @(posedge clk40_i); #1;
        req0_i = 1'b1; we0_i = 1'b1; addr0_i = 16'h2222; wdata0_i = 8'h5A;
        sb.push_back('{1'b0, 19'h02222, 1'b1, 8'h5A});
        for (int k = 0; k < 10 && wen_n_o; k++) @(negedge clk40_i);
        addr0_i = 16'hDEAD; wdata0_i = 8'hEE;
        wait_acks(1, 20);
        drop_reqs();
        check_idle(19'h02222);
        check("idle_data_hold", data_o, 8'h5A);

        // Reset during a write access aborts it; pending req1 served afterwards
        do_reset();
        @(posedge clk40_i); #1;
        req1_i = 1'b1; we1_i = 1'b1; addr1_i = 16'h0ABC; wdata1_i = 8'h3C;
        for (int k = 0; k < 10 && wen_n_o; k++) @(negedge clk40_i);
        check("abort_in_access", wen_n_o, 1'b0);
        reset_n_i = 1'b0;
        #1;
        check("abort_strobes", {cen_n_o, oen_n_o, wen_n_o, data_oe_o, ack0_o, ack1_o, busy_o}, 7'b1110000);
        repeat (3) @(negedge clk40_i);
        sb.push_back('{1'b1, 19'h10ABC, 1'b1, 8'h3C});
        reset_n_i = 1'b1;
        wait_acks(1, 20);
        drop_reqs();

        // Continuous contention after reset: 0,1,0,1 with 5-cycle spacing
        do_reset();
        @(posedge clk40_i); #1;
        req0_i = 1'b1; we0_i = 1'b0; addr0_i = 16'h0010; data_i = 8'h11;
        req1_i = 1'b1; we1_i = 1'b1; addr1_i = 16'h0020; wdata1_i = 8'h22;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1'b0, 19'h00010, 1'b0, 8'h11});
            sb.push_back('{1'b1, 19'h10020, 1'b1, 8'h22});
        end
        wait_acks(4, 40);
        drop_reqs();
        for (int k = 1; k < 4; k++)
            check("ack_period", (ack_cycles.size() > k) ? ack_cycles[k] - ack_cycles[k-1] : 0, W + 3);

        // WAIT_CYCLES sweep on the 1- and 15-cycle instances
        sb_en = 1'b0;
        do_reset();
        @(posedge clk40_i); #1;
        req1_i = 1'b1; we1_i = 1'b0; addr1_i = 16'hABCD; data_i = 8'h66;
        n0 = cyc; c1 = -1; c15 = -1; lo1 = 0; lo15 = 0; got1 = 1'b0; got15 = 1'b0;
        for (int k = 0; k < 40 && !(got1 && got15); k++) begin
            @(negedge clk40_i);
            if (!got1) begin
                if (!oen_w1) lo1++;
                if (ack1_w1) begin
                    got1 = 1'b1; c1 = cyc;
                    check("w1_addr_rdata", {addr_w1, rdata_w1}, {19'h1ABCD, 8'h66});
                end
            end
            if (!got15) begin
                if (!oen_w15) lo15++;
                if (ack1_w15) begin
                    got15 = 1'b1; c15 = cyc;
                    check("w15_addr_rdata", {addr_w15, rdata_w15}, {19'h0ABCD, 8'h66});
                end
            end
        end
        check("w1_latency", c1 - n0, 3);
        check("w1_oen_cycles", lo1, 1);
        check("w15_latency", c15 - n0, 17);
        check("w15_oen_cycles", lo15, 15);
        drop_reqs();
        do_reset();
        sb_en = 1'b1;

        repeat (3) @(negedge clk40_i);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/extram_arbiter.md
EXTRAM_ARBITER -- requirements
Module: extram_arbiter

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, strobe-active cycles per access (legal 1..15).
REQ-002 SHALL provide parameter BANKED, default 1; 1 = requester index drives addr bit 16, 0 = addr bit 16 forced 0.
REQ-003 clk40_i  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n_i  input  1  asynchronous active-low reset.
REQ-005 req0_i / req1_i  input  1 each  access request, CPU0 / CPU1.
REQ-006 we0_i / we1_i  input  1 each  1 = write, 0 = read.
REQ-007 addr0_i / addr1_i  input  16 each  requester byte address.
REQ-008 wdata0_i / wdata1_i  input  8 each  write data.
REQ-009 ack0_o / ack1_o  output  1 each  one-cycle completion pulse.
REQ-010 rdata_o  output  8  read data, valid while ackN_o high, held until next read capture.
REQ-011 addr_o  output  19  SRAM address = {2'b00, bank, latched addr}.
REQ-012 data_o  output  8  SRAM write data; data_oe_o  output  1  data_o drive enable.
REQ-013 data_i  input  8  SRAM read data.
REQ-014 cen_n_o, oen_n_o, wen_n_o  output  1 each  active-low SRAM strobes.
REQ-015 grant_o  output  1  index of current/last granted requester; busy_o  output  1  high in any state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-017 IDLE: sample req0_i/req1_i; if any high, latch winner's we/addr/wdata, set grant_o, go SETUP; else stay.
REQ-018 Arbitration: single request wins; both high -> requester not in last_grant wins (round-robin); last_grant updates on entering SETUP.
REQ-019 SETUP (1 cycle): addr_o valid, cen_n_o=0, oen_n_o=wen_n_o=1, data_oe_o=we.
REQ-020 ACCESS (exactly WAIT_CYCLES cycles, 4-bit down counter): cen_n_o=0; read -> oen_n_o=0; write -> wen_n_o=0, data_oe_o=1.
REQ-021 Read capture: data_i registered into rdata_o on the edge ending the last ACCESS cycle.
REQ-022 DONE (1 cycle): oen_n_o=wen_n_o=1, cen_n_o=0, addr_o and data_o/data_oe_o held (write hold time); ack of granted requester =1, other ack=0.
REQ-023 Latency: request sampled in IDLE cycle n -> ack high in cycle n+2+WAIT_CYCLES; back-to-back period 3+WAIT_CYCLES cycles.
REQ-024 Requester SHALL hold req/we/addr/wdata stable until ack; req still high in the IDLE cycle after ack is a new request.
REQ-025 Inputs changing after the IDLE latch SHALL NOT affect the running access.
REQ-026 Strobes SHALL be glitch-free registered outputs; oen_n_o and wen_n_o never low simultaneously; data_oe_o never high while oen_n_o=0.
REQ-027 Outside SETUP/ACCESS/DONE: cen_n_o=1, data_oe_o=0, addr_o holds last value.
REQ-028 Only one ack high per cycle; acks never high outside DONE.

Reset
REQ-029 reset_n_i low SHALL immediately force IDLE, cen_n_o=oen_n_o=wen_n_o=1, data_oe_o=0, ack0_o=ack1_o=0, addr_o=0, data_o=0, rdata_o=0, grant_o=0, busy_o=0, last_grant=1, counter=0.
REQ-030 Reset mid-access SHALL abort without ack; after release first IDLE sample starts fresh arbitration (CPU0 wins tie).

Verification
REQ-031 Single read: WAIT_CYCLES=2, req0 read addr 16'h1234, data_i=8'hA5 -> addr_o=19'h01234, oen_n_o low 2 cycles, ack0_o in cycle n+4, rdata_o=8'hA5.
REQ-032 Single write: req1 write addr 16'h00FF data 8'h3C, BANKED=1 -> addr_o=19'h100FF, wen_n_o low 2 cycles, data_oe_o high SETUP..DONE, ack1_o once.
REQ-033 Contention: req0 and req1 held high continuously post-reset -> grants alternate 0,1,0,1; each ack period 5 cycles.
REQ-034 Reset mid-ACCESS: assert reset_n_i low during write ACCESS -> strobes high and data_oe_o low in same cycle, no ack; after release, pending req1 served normally.
REQ-035 Parameter sweep: WAIT_CYCLES=1 and 15 -> strobe low exactly 1 / 15 cycles, ack at n+3 / n+17.
REQ-036 Input change: alter addr0_i/wdata0_i during ACCESS -> addr_o/data_o unchanged until DONE ends.
